// File: rtl/eth_mac_tx_frame_arbiter_if.sv
// Byte-lane AXI-Stream bundle. LANES streams share one bundle with data packed
// lane-major, so lane c owns tdata[c*8 +: 8] and bit c of each sideband vector.
interface eth_mac_tx_frame_arbiter_if #(
  parameter int LANES = 1
) ();
  logic [LANES*8-1:0] tdata;
  logic [LANES-1:0]   tvalid;
  logic [LANES-1:0]   tready;
  logic [LANES-1:0]   tlast;
  logic [LANES-1:0]   tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input  tready);
  modport slave  (input  tdata, input  tvalid, input  tlast, input  tuser, output tready);
endinterface

// File: rtl/eth_mac_tx_frame_arbiter.sv
// Frame-level N:1 arbiter for the MAC TX path: whole frames only, runaway frames cut at
// MAX_FRAME_LEN and drained, per-channel frame counters and completion/truncation toggles.

module eth_mac_tx_frame_arbiter_chan_stat #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 tx_clk,
  input  logic                 tx_rst,
  input  logic                 frame_done,
  input  logic                 frame_trunc,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 frame_tog,
  output logic                 trunc_tog
);
  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      cnt       <= '0;
      frame_tog <= 1'b0;
      trunc_tog <= 1'b0;
    end else begin
      if (frame_done) begin
        cnt       <= cnt + 1'b1;
        frame_tog <= ~frame_tog;
      end
      if (frame_trunc) trunc_tog <= ~trunc_tog;
    end
  end
endmodule

module eth_mac_tx_frame_arbiter #(
  parameter int    CHANNELS      = 4,
  parameter string ARB_MODE      = "RR",
  parameter int    CNT_WIDTH     = 16,
  parameter int    MAX_FRAME_LEN = 2048,
  parameter int    IDX_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                          tx_clk,
  input  logic                          tx_rst,
  eth_mac_tx_frame_arbiter_if.slave     s_axis,
  eth_mac_tx_frame_arbiter_if.master    m_axis,
  input  logic [CHANNELS-1:0]           chan_enable,
  output logic [IDX_W-1:0]              active_chan,
  output logic                          busy,
  output logic [CHANNELS*CNT_WIDTH-1:0] frame_cnt,
  output logic [CHANNELS-1:0]           frame_toggle,
  output logic [CHANNELS-1:0]           trunc_toggle
);
  localparam int BEAT_W = $clog2(MAX_FRAME_LEN);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_FRAME_LEN - 1);

  typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;

  state_t                             state, state_nxt;
  logic [IDX_W-1:0]                   grant, grant_nxt;
  logic [IDX_W-1:0]                   rr_ptr, rr_ptr_nxt;
  logic [BEAT_W-1:0]                  beat_cnt, beat_nxt;
  logic [CHANNELS-1:0]                req;
  logic [IDX_W-1:0]                   pick;
  logic                               sel_valid, sel_last, sel_user;
  logic [7:0]                         sel_data;
  logic                               trunc_beat, hs, frame_end, trunc_ev;
  logic [CHANNELS-1:0]                done_vec, trunc_vec;
  logic [CHANNELS-1:0][CNT_WIDTH-1:0] cnt_arr;

  assign req = s_axis.tvalid & chan_enable;

  // Winner among requesters; only consumed in IDLE, so it never preempts a frame.
  always_comb begin
    pick = '0;
    if (ARB_MODE == "PRIO") begin
      for (int i = CHANNELS - 1; i >= 0; i--)
        if (req[i]) pick = IDX_W'(i);
    end else begin
      // Walk downward so the closest requester above the pointer is written last.
      for (int i = CHANNELS; i >= 1; i--) begin
        int j;
        j = int'(rr_ptr) + i;
        if (j >= CHANNELS) j = j - CHANNELS;
        if (req[j]) pick = IDX_W'(j);
      end
    end
  end

  assign sel_valid = s_axis.tvalid[grant];
  assign sel_last  = s_axis.tlast[grant];
  assign sel_user  = s_axis.tuser[grant];
  assign sel_data  = s_axis.tdata[int'(grant)*8 +: 8];

  // The MAX_FRAME_LEN-th beat without tlast is forced to close the frame as bad.
  assign trunc_beat = (state == XFER) && (beat_cnt == LAST_BEAT) && !sel_last;
  assign hs         = (state == XFER) && sel_valid && m_axis.tready[0];
  assign frame_end  = hs && (sel_last || trunc_beat);
  assign trunc_ev   = hs && trunc_beat;

  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      state    <= IDLE;
      grant    <= '0;
      rr_ptr   <= IDX_W'(CHANNELS - 1);
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      rr_ptr   <= rr_ptr_nxt;
      beat_cnt <= beat_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant;
    rr_ptr_nxt    = rr_ptr;
    beat_nxt      = beat_cnt;
    m_axis.tdata  = '0;
    m_axis.tvalid = '0;
    m_axis.tlast  = '0;
    m_axis.tuser  = '0;
    s_axis.tready = '0;
    case (state)
      IDLE: begin
        if (|req) begin
          grant_nxt  = pick;
          rr_ptr_nxt = pick;
          beat_nxt   = '0;
          state_nxt  = XFER;
        end
      end
      XFER: begin
        m_axis.tdata         = sel_data;
        m_axis.tvalid[0]     = sel_valid;
        m_axis.tlast[0]      = sel_last | trunc_beat;
        m_axis.tuser[0]      = sel_user | trunc_beat;
        s_axis.tready[grant] = m_axis.tready[0];
        if (hs) beat_nxt = beat_cnt + 1'b1;
        if (frame_end) state_nxt = trunc_beat ? DRAIN : IDLE;
      end
      DRAIN: begin
        // Swallow the rest of the cut frame; the MAC already saw its tlast.
        s_axis.tready[grant] = 1'b1;
        if (sel_valid && sel_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign done_vec  = frame_end ? (CHANNELS'(1) << grant) : '0;
  assign trunc_vec = trunc_ev  ? (CHANNELS'(1) << grant) : '0;

  eth_mac_tx_frame_arbiter_chan_stat #(.CNT_WIDTH(CNT_WIDTH)) u_stat [CHANNELS-1:0] (
    .tx_clk      (tx_clk),
    .tx_rst      (tx_rst),
    .frame_done  (done_vec),
    .frame_trunc (trunc_vec),
    .cnt         (cnt_arr),
    .frame_tog   (frame_toggle),
    .trunc_tog   (trunc_toggle)
  );

  assign frame_cnt   = cnt_arr;
  assign active_chan = grant;
  assign busy        = (state != IDLE);
endmodule

// File: tb/tb_eth_mac_tx_frame_arbiter.sv
// Drives an RR and a PRIO arbiter (4 channels, 4-bit counters, 64-beat limit) from the same
// frame queues and checks every cycle against a frame-level reference model.
module tb_eth_mac_tx_frame_arbiter;
  localparam int MAXF = 64;

  logic tx_clk = 1'b0;
  logic tx_rst = 1'b1;
  always #5 tx_clk = ~tx_clk;

  logic [3:0]       chan_enable = 4'hf;
  logic [3:0]       en_cfg = 4'hf;
  logic [1:0][3:0]  d_valid = '0, d_last = '0, d_user = '0, s_ready;
  logic [1:0][31:0] d_data = '0;
  logic [1:0]       m_ready = '0, m_valid, m_last, m_user, bsy;
  logic [1:0][7:0]  m_data;
  logic [1:0][1:0]  act;
  logic [1:0][15:0] fcnt;
  logic [1:0][3:0]  ftog, ttog;

  eth_mac_tx_frame_arbiter_if #(.LANES(4)) s_a ();
  eth_mac_tx_frame_arbiter_if #(.LANES(4)) s_b ();
  eth_mac_tx_frame_arbiter_if #(.LANES(1)) m_a ();
  eth_mac_tx_frame_arbiter_if #(.LANES(1)) m_b ();

  assign s_a.tdata = d_data[0];  assign s_a.tvalid = d_valid[0];
  assign s_a.tlast = d_last[0];  assign s_a.tuser  = d_user[0];
  assign s_b.tdata = d_data[1];  assign s_b.tvalid = d_valid[1];
  assign s_b.tlast = d_last[1];  assign s_b.tuser  = d_user[1];
  assign s_ready[0] = s_a.tready;
  assign s_ready[1] = s_b.tready;
  assign m_a.tready = m_ready[0];
  assign m_b.tready = m_ready[1];
  assign m_valid = {m_b.tvalid, m_a.tvalid};
  assign m_last  = {m_b.tlast,  m_a.tlast};
  assign m_user  = {m_b.tuser,  m_a.tuser};
  assign m_data  = {m_b.tdata,  m_a.tdata};

  eth_mac_tx_frame_arbiter #(.CHANNELS(4), .ARB_MODE("RR"), .CNT_WIDTH(4), .MAX_FRAME_LEN(MAXF)) dut_a (
    .tx_clk(tx_clk), .tx_rst(tx_rst), .s_axis(s_a), .m_axis(m_a), .chan_enable(chan_enable),
    .active_chan(act[0]), .busy(bsy[0]), .frame_cnt(fcnt[0]), .frame_toggle(ftog[0]),
    .trunc_toggle(ttog[0]));

  eth_mac_tx_frame_arbiter #(.CHANNELS(4), .ARB_MODE("PRIO"), .CNT_WIDTH(4), .MAX_FRAME_LEN(MAXF)) dut_b (
    .tx_clk(tx_clk), .tx_rst(tx_rst), .s_axis(s_b), .m_axis(m_b), .chan_enable(chan_enable),
    .active_chan(act[1]), .busy(bsy[1]), .frame_cnt(fcnt[1]), .frame_toggle(ftog[1]),
    .trunc_toggle(ttog[1]));

  // Reference model: per-DUT source queues {tuser,tlast,data}, frame owner, beat count.
  logic [9:0] srcq[8][$];
  int  glog[2][$];
  int  olen[2][$];
  int  owner[2], ptr[2], beats[2], curlen[2];
  bit  drain[2];
  int  cnt[2][4];
  bit  ftm[2][4], ttm[2][4];
  int  gap_pct = 0, rdy_pct = 100;
  int  checks = 0, errors = 0;

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d: got %0h expected %0h", tag, d, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      owner[d] = -1; ptr[d] = 3; beats[d] = 0; curlen[d] = 0; drain[d] = 1'b0;
      for (int c = 0; c < 4; c++) begin cnt[d][c] = 0; ftm[d][c] = 1'b0; ttm[d][c] = 1'b0; end
    end
  endtask

  // d==0 round-robin from ptr+1, d==1 lowest index first.
  function automatic int pick(input int d, input logic [3:0] req);
    int r;
    r = -1;
    if (d == 1) begin
      for (int c = 3; c >= 0; c--) if (req[c]) r = c;
    end else begin
      for (int i = 4; i >= 1; i--) if (req[(ptr[d] + i) % 4]) r = (ptr[d] + i) % 4;
    end
    return r;
  endfunction

  task automatic push_frame(input int c, input int len, input bit bad);
    logic [9:0] b;
    for (int i = 0; i < len; i++) begin
      b = {bad && (i == len - 1), i == len - 1, 8'($urandom)};
      srcq[c].push_back(b);
      srcq[4 + c].push_back(b);
    end
  endtask

  task automatic step(input int d);
    logic [3:0]  req, exp_ft, exp_tt;
    logic [15:0] exp_cnt;
    logic [9:0]  f;
    int          o, q;
    bit          trunc;
    for (int c = 0; c < 4; c++) begin
      exp_cnt[c*4 +: 4] = 4'(cnt[d][c]);
      exp_ft[c] = ftm[d][c];
      exp_tt[c] = ttm[d][c];
    end
    chk("frame_cnt", d, fcnt[d], exp_cnt);
    chk("frame_toggle", d, ftog[d], exp_ft);
    chk("trunc_toggle", d, ttog[d], exp_tt);
    chk("busy", d, bsy[d], owner[d] >= 0);
    if (owner[d] < 0) begin
      chk("m_valid_idle", d, m_valid[d], 0);
      chk("s_ready_idle", d, s_ready[d], 0);
      req = d_valid[d] & chan_enable;
      if (req != 0) begin
        o = pick(d, req);
        owner[d] = o; ptr[d] = o; beats[d] = 0; drain[d] = 1'b0;
        glog[d].push_back(o);
      end
    end else begin
      o = owner[d];
      q = d * 4 + o;
      chk("active_chan", d, act[d], o);
      if (!drain[d]) begin
        chk("m_valid", d, m_valid[d], d_valid[d][o]);
        chk("s_ready", d, s_ready[d], m_ready[d] ? (4'b1 << o) : 4'b0);
        if (d_valid[d][o]) begin
          f = srcq[q][0];
          trunc = (beats[d] == MAXF - 1) && !f[8];
          chk("m_beat", d, {m_user[d], m_last[d], m_data[d]}, {f[9] | trunc, f[8] | trunc, f[7:0]});
          if (m_ready[d]) begin
            srcq[q].delete(0);
            beats[d]++; curlen[d]++;
            if (f[8] || trunc) begin
              cnt[d][o]++; ftm[d][o] = ~ftm[d][o];
              olen[d].push_back(curlen[d]); curlen[d] = 0;
              if (trunc) begin ttm[d][o] = ~ttm[d][o]; drain[d] = 1'b1; end
              else owner[d] = -1;
            end
          end
        end
      end else begin
        chk("m_valid_drain", d, m_valid[d], 0);
        chk("s_ready_drain", d, s_ready[d], 4'b1 << o);
        if (d_valid[d][o]) begin
          f = srcq[q][0];
          srcq[q].delete(0);
          if (f[8]) begin owner[d] = -1; drain[d] = 1'b0; end
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge tx_clk);
    chan_enable = en_cfg;
    for (int d = 0; d < 2; d++) begin
      m_ready[d] = ($urandom_range(99) < rdy_pct);
      for (int c = 0; c < 4; c++) begin
        int q;
        logic [9:0] f;
        q = d * 4 + c;
        f = {2'b00, 8'($urandom)};
        d_valid[d][c] = 1'b0;
        if (srcq[q].size() > 0 && $urandom_range(99) >= gap_pct) begin
          f = srcq[q][0];
          d_valid[d][c] = 1'b1;
        end
        d_data[d][c*8 +: 8] = f[7:0];
        d_last[d][c] = f[8];
        d_user[d][c] = f[9];
      end
    end
    #1;
    step(0);
    step(1);
  endtask

  function automatic bit all_idle();
    bit r;
    r = (owner[0] < 0) && (owner[1] < 0);
    for (int q = 0; q < 8; q++) if (srcq[q].size() != 0) r = 1'b0;
    return r;
  endfunction

  task automatic flush(input string tag, input int budget);
    int n;
    n = 0;
    while (n < budget && !all_idle()) begin tick(); n++; end
    chk(tag, 0, n >= budget, 0);
    tick(); tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_m_valid"}, d, m_valid[d], 0);
      chk({tag, "_m_beat"}, d, {m_user[d], m_last[d], m_data[d]}, 0);
      chk({tag, "_s_ready"}, d, s_ready[d], 0);
      chk({tag, "_busy"}, d, bsy[d], 0);
      chk({tag, "_active"}, d, act[d], 0);
      chk({tag, "_cnt"}, d, fcnt[d], 0);
      chk({tag, "_toggles"}, d, {ftog[d], ttog[d]}, 0);
    end
  endtask

  task automatic reset_mid_frame();
    logic [9:0] f;
    @(negedge tx_clk);
    d_valid = '0; d_last = '0; d_user = '0; m_ready = '0;
    tx_rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    // The upstream FIFO discards the abandoned remainder of the frame.
    for (int d = 0; d < 2; d++) begin
      if (owner[d] >= 0 && (beats[d] > 0 || drain[d])) begin
        while (srcq[d*4 + owner[d]].size() > 0) begin
          f = srcq[d*4 + owner[d]][0];
          srcq[d*4 + owner[d]].delete(0);
          if (f[8]) break;
        end
      end
    end
    model_reset();
    repeat (2) @(negedge tx_clk);
    tx_rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, idx, ch1_after;
    model_reset();
    @(negedge tx_clk);
    #1;
    check_reset_outputs("rst_init");
    @(negedge tx_clk);
    tx_rst = 1'b0;

    // 3 x 64-beat frames per channel: exactly MAX beats is a normal end.
    for (int k = 0; k < 3; k++) for (int c = 0; c < 4; c++) push_frame(c, 64, 1'b0);
    flush("t1_timeout", 2000);
    chk("t1_rr_count", 0, glog[0].size(), 12);
    chk("t1_prio_count", 1, glog[1].size(), 12);
    for (int i = 0; i < 12; i++) begin
      chk("t1_rr_order", 0, glog[0][i], i % 4);
      chk("t1_prio_order", 1, glog[1][i], i / 3);
    end
    chk("t1_cnt", 0, fcnt[0], 16'h3333);
    chk("t1_cnt", 1, fcnt[1], 16'h3333);
    chk("t1_no_trunc", 0, ttog[0], 0);

    // Runaway 100-byte frame on ch2, then a short intact one.
    olen[0].delete(); olen[1].delete();
    push_frame(2, 100, 1'b0);
    push_frame(2, 10, 1'b1);
    flush("t3_timeout", 1000);
    for (int d = 0; d < 2; d++) begin
      chk("t3_frames", d, olen[d].size(), 2);
      chk("t3_len_cut", d, olen[d][0], 64);
      chk("t3_len_next", d, olen[d][1], 10);
      chk("t3_trunc_tog", d, ttog[d], 4'b0100);
    end

    // Only ch1/ch3 enabled; drop ch1 while it is mid-frame.
    glog[0].delete(); glog[1].delete();
    for (int k = 0; k < 2; k++) for (int c = 0; c < 4; c++) push_frame(c, 30, 1'b0);
    en_cfg = 4'b1010;
    n = 0;
    while (n < 500 && !(owner[0] == 1 && beats[0] >= 3 && !drain[0])) begin tick(); n++; end
    chk("t5_wait_ch1", 0, n >= 500, 0);
    idx = glog[0].size();
    en_cfg = 4'b1000;
    n = 0;
    while (n < 1000 && !(srcq[3].size() == 0 && srcq[7].size() == 0 && owner[0] < 0 && owner[1] < 0)) begin
      tick(); n++;
    end
    chk("t5_wait_ch3", 0, n >= 1000, 0);
    ch1_after = 0;
    for (int i = 0; i < glog[0].size(); i++) begin
      chk("t5_rr_granted", 0, glog[0][i] inside {1, 3}, 1);
      if (i >= idx && glog[0][i] == 1) ch1_after++;
    end
    for (int i = 0; i < glog[1].size(); i++) chk("t5_prio_granted", 1, glog[1][i] inside {1, 3}, 1);
    chk("t5_no_ch1_regrant", 0, ch1_after, 0);
    chk("t5_ch1_left", 0, srcq[1].size(), 30);
    chk("t5_ch0_left", 0, srcq[0].size(), 60);
    chk("t5_ch2_left", 0, srcq[2].size(), 60);
    en_cfg = 4'b1111;
    flush("t5_flush", 2000);

    // 200 random frames, random MAC backpressure and upstream gaps.
    gap_pct = 25; rdy_pct = 50;
    for (int k = 0; k < 50; k++)
      for (int c = 0; c < 4; c++) push_frame(c, $urandom_range(70, 1), $urandom_range(3) == 0);
    flush("t4_timeout", 60000);
    gap_pct = 0; rdy_pct = 100;

    // Reset in the middle of a ch1 frame, then 17 frames on ch0 with 4-bit counters.
    push_frame(1, 50, 1'b0);
    n = 0;
    while (n < 200 && !(owner[0] == 1 && beats[0] >= 10)) begin tick(); n++; end
    chk("t6_wait_ch1", 0, n >= 200, 0);
    reset_mid_frame();
    glog[0].delete(); glog[1].delete();
    for (int k = 0; k < 17; k++) push_frame(0, 3, 1'b0);
    for (int c = 1; c < 4; c++) push_frame(c, 5, 1'b0);
    flush("t6_timeout", 2000);
    chk("t6_first_grant", 0, glog[0][0], 0);
    chk("t6_prio_ch0_last", 1, glog[1][16], 0);
    chk("t6_prio_then_ch1", 1, glog[1][17], 1);
    chk("t6_cnt_wrap", 0, fcnt[0], 16'h1111);
    chk("t6_cnt_wrap", 1, fcnt[1], 16'h1111);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
